// File: rtl/mpt_pkg.sv
// Shared types and helpers for the MPT walk pipeline memory ports.
package mpt_pkg;

    localparam int MEM_DATA_W = 32;

    typedef struct packed {
        logic [MEM_DATA_W-1:0] rdata;
        logic                  err;
    } mem_resp_t;

    // Number of low byte-address bits that select a byte within one data word.
    function automatic int mem_addr_off(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/mem_resp_delay_line.sv
// Fixed-latency shift register of {valid, payload}; reset discards everything in flight.
module mem_resp_delay_line #(
    parameter int  LATENCY = 2,
    parameter type dtype   = logic
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic vld_i,
    input  dtype data_i,
    output logic vld_o,
    output dtype data_o
);

    logic [LATENCY-1:0] vld_q;
    dtype               data_q [LATENCY];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            vld_q[0]  <= vld_i;
            data_q[0] <= data_i;
            for (int i = 1; i < LATENCY; i++) begin
                vld_q[i]  <= vld_q[i-1];
                data_q[i] <= data_q[i-1];
            end
        end
    end

    assign vld_o  = vld_q[LATENCY-1];
    assign data_o = data_q[LATENCY-1];

endmodule

// File: rtl/mpt_mem_responder.sv
// Fixed-latency SRAM responder for the req/gnt/valid protocol, backed by a byte-enabled word array.
module mpt_mem_responder
    import mpt_pkg::*;
#(
    parameter int MEMORY_DATA_WIDTH = MEM_DATA_W,
    parameter int MEMORY_ADDR_WIDTH = 32,
    parameter int DEPTH             = 1024,
    parameter int READ_LATENCY      = 2
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  memory_slave_mem_req,
    output logic                                  memory_slave_mem_gnt,
    input  logic [MEMORY_ADDR_WIDTH-1:0]          memory_slave_mem_addr,
    input  logic                                  memory_slave_mem_we,
    input  logic [MEMORY_DATA_WIDTH/8-1:0]        memory_slave_mem_be,
    input  logic [MEMORY_DATA_WIDTH-1:0]          memory_slave_mem_wdata,
    output logic                                  memory_slave_mem_valid,
    output logic [MEMORY_DATA_WIDTH-1:0]          memory_slave_mem_rdata,
    input  logic                                  stall_i,
    output logic                                  err_o,
    output logic [$clog2(READ_LATENCY+1)-1:0]     outstanding_o
);

    localparam int OFF   = mem_addr_off(MEMORY_DATA_WIDTH);
    localparam int BE_W  = MEMORY_DATA_WIDTH / 8;
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(READ_LATENCY + 1);

    // Local response type so the payload width follows MEMORY_DATA_WIDTH.
    typedef struct packed {
        logic [MEMORY_DATA_WIDTH-1:0] rdata;
        logic                         err;
    } resp_t;

    logic [MEMORY_DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [MEMORY_ADDR_WIDTH-1:0] word_addr;
    logic [IDX_W-1:0]             idx;
    logic                         in_range;
    logic                         hs;
    resp_t                        resp_in;
    resp_t                        resp_out;
    logic                         resp_vld;
    logic [CNT_W-1:0]             cnt_q, cnt_d;

    assign memory_slave_mem_gnt = memory_slave_mem_req & ~stall_i & ~rst_i;
    assign hs                   = memory_slave_mem_req & memory_slave_mem_gnt;

    // Range check uses the full word address so high addresses never alias into the array.
    assign word_addr = memory_slave_mem_addr >> OFF;
    assign in_range  = word_addr < MEMORY_ADDR_WIDTH'(DEPTH);
    assign idx       = word_addr[IDX_W-1:0];

    always_ff @(posedge clk_i) begin
        if (hs && memory_slave_mem_we && in_range) begin
            for (int b = 0; b < BE_W; b++) begin
                if (memory_slave_mem_be[b]) begin
                    mem_q[idx][b*8 +: 8] <= memory_slave_mem_wdata[b*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        resp_in = '0;
        if (hs) begin
            resp_in.err = ~in_range;
            if (!memory_slave_mem_we && in_range) begin
                resp_in.rdata = mem_q[idx];
            end
        end
    end

    mem_resp_delay_line #(
        .LATENCY (READ_LATENCY),
        .dtype   (resp_t)
    ) u_delay (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .vld_i  (hs),
        .data_i (resp_in),
        .vld_o  (resp_vld),
        .data_o (resp_out)
    );

    always_comb begin
        cnt_d = cnt_q;
        if (hs && !resp_vld) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!hs && resp_vld) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign memory_slave_mem_valid = resp_vld;
    assign memory_slave_mem_rdata = resp_out.rdata;
    assign err_o                  = resp_out.err;
    assign outstanding_o          = cnt_q;

endmodule

// File: tb/tb_mpt_mem_responder.sv
// Directed bench for mpt_mem_responder with hand-computed expected responses.
module tb_mpt_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        gnt;
    logic [31:0] addr = '0;
    logic        we = 1'b0;
    logic [3:0]  be = '0;
    logic [31:0] wdata = '0;
    logic        valid;
    logic [31:0] rdata;
    logic        stall = 1'b0;
    logic        err;
    logic [1:0]  outstanding;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int max_out = 0;
    int last_rc = 0;
    int rc [4];

    logic [31:0] rdq [$];
    bit          errq [$];
    int          rcq [$];
    int          hcq [$];

    mpt_mem_responder #(
        .MEMORY_DATA_WIDTH (32),
        .MEMORY_ADDR_WIDTH (32),
        .DEPTH             (1024),
        .READ_LATENCY      (2)
    ) dut (
        .clk_i                  (clk),
        .rst_i                  (rst),
        .memory_slave_mem_req   (req),
        .memory_slave_mem_gnt   (gnt),
        .memory_slave_mem_addr  (addr),
        .memory_slave_mem_we    (we),
        .memory_slave_mem_be    (be),
        .memory_slave_mem_wdata (wdata),
        .memory_slave_mem_valid (valid),
        .memory_slave_mem_rdata (rdata),
        .stall_i                (stall),
        .err_o                  (err),
        .outstanding_o          (outstanding)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (req && gnt) hcq.push_back(cyc);
        if (valid) begin
            rdq.push_back(rdata);
            errq.push_back(err);
            rcq.push_back(cyc);
        end
        if (int'(outstanding) > max_out) max_out = int'(outstanding);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic w, input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
        @(posedge clk);
        #1;
        req = 1'b1; we = w; addr = a; be = b; wdata = d;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0;
    endtask

    task automatic expect_resp(input string tag, input logic [31:0] exp_d, input logic exp_e);
        int hc;
        for (int i = 0; i < 10 && rdq.size() == 0; i++) begin
            @(posedge clk);
            #2;
        end
        if (rdq.size() == 0) begin
            check({tag, "_vld"}, 32'(rdq.size()), 32'd1);
            return;
        end
        last_rc = rcq.pop_front();
        check({tag, "_rdata"}, rdq.pop_front(), exp_d);
        check({tag, "_err"}, 32'(errq.pop_front()), 32'(exp_e));
        hc = (hcq.size() != 0) ? hcq.pop_front() : -100;
        check({tag, "_lat"}, 32'(last_rc - hc), 32'd2);
    endtask

    initial begin
        // Reset state, with req held high to observe gnt gated by reset.
        req = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_out", 32'(outstanding), 32'd0);
        req = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;

        // Full-word write then immediate read of the same word.
        issue(1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
        issue(1'b0, 32'h10, 4'h0, 32'h0);
        idle();
        expect_resp("t1_wr", 32'h0, 1'b0);
        expect_resp("t1_rd", 32'hDEADBEEF, 1'b0);

        // Partial byte-enable write.
        issue(1'b1, 32'h20, 4'hF, 32'h11223344);
        issue(1'b1, 32'h20, 4'b0101, 32'hAABBCCDD);
        issue(1'b0, 32'h20, 4'h0, 32'h0);
        idle();
        expect_resp("t2_wr0", 32'h0, 1'b0);
        expect_resp("t2_wr1", 32'h0, 1'b0);
        expect_resp("t2_rd", 32'h11BB33DD, 1'b0);

        // Preload then four back-to-back reads.
        for (int i = 0; i < 4; i++) issue(1'b1, 32'(i * 4), 4'hF, 32'(i + 1));
        idle();
        for (int i = 0; i < 4; i++) expect_resp("t3_pre", 32'h0, 1'b0);
        max_out = 0;
        for (int i = 0; i < 4; i++) issue(1'b0, 32'(i * 4), 4'h0, 32'h0);
        idle();
        for (int i = 0; i < 4; i++) begin
            expect_resp($sformatf("t3_rd%0d", i), 32'(i + 1), 1'b0);
            rc[i] = last_rc;
        end
        for (int i = 1; i < 4; i++) check($sformatf("t3_b2b%0d", i), 32'(rc[i] - rc[0]), 32'(i));
        check("t3_max_out", 32'(max_out), 32'd2);
        @(negedge clk);
        check("t3_out_idle", 32'(outstanding), 32'd0);

        // Stall for three cycles with req held.
        @(posedge clk);
        #1 stall = 1'b1;
        req = 1'b1; we = 1'b0; addr = 32'h10; be = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("t4_gnt%0d", i), 32'(gnt), 32'd0);
            check($sformatf("t4_vld%0d", i), 32'(valid), 32'd0);
            @(posedge clk);
            #1;
        end
        stall = 1'b0;
        @(negedge clk);
        check("t4_gnt_rel", 32'(gnt), 32'd1);
        idle();
        expect_resp("t4_rd", 32'hDEADBEEF, 1'b0);
        repeat (4) @(posedge clk);
        #2;
        check("t4_single", 32'(rdq.size()), 32'd0);

        // Out-of-range read and write; word 0 must not be aliased.
        issue(1'b0, 32'h1000, 4'h0, 32'h0);
        issue(1'b1, 32'h1000, 4'hF, 32'hFFFFFFFF);
        issue(1'b0, 32'h0, 4'h0, 32'h0);
        idle();
        expect_resp("t5_oor_rd", 32'h0, 1'b1);
        expect_resp("t5_oor_wr", 32'h0, 1'b1);
        expect_resp("t5_word0", 32'h1, 1'b0);

        // Reset one cycle after a read grant discards the response.
        issue(1'b0, 32'h20, 4'h0, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("t6_vld%0d", i), 32'(valid), 32'd0);
            check($sformatf("t6_out%0d", i), 32'(outstanding), 32'd0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        check("t6_no_resp", 32'(rdq.size()), 32'd0);
        hcq.delete();
        issue(1'b0, 32'h20, 4'h0, 32'h0);
        idle();
        expect_resp("t6_keep", 32'h11BB33DD, 1'b0);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
